// File: rtl/mat_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mat_mul_pkg
// Description : Constants shared by the 2x2 matrix multiplier result path:
//               word count, word index names, result width and the
//               encodings of the serializer read-FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package mat_mul_pkg;

    localparam int MAT_WORDS = 4;
    localparam int WORD_IDX_W = 2;

    // Position of each result word inside a matrix and on out_idx
    localparam int IDX_W = 0;
    localparam int IDX_X = 1;
    localparam int IDX_Y = 2;
    localparam int IDX_Z = 3;

    localparam int RES_W = 32;

    // Read FSM state encodings
    localparam logic [0:0] RS_EMPTY = 1'b0;
    localparam logic [0:0] RS_SEND  = 1'b1;

endpackage : mat_mul_pkg
`default_nettype wire

// File: rtl/mat_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mat_result_fifo
// Description : DEPTH-entry queue of whole matrices (MAT_WORDS words each).
//               Push and pop may occur together, including when full; the
//               caller only pushes when a slot is free or is being freed.
// Revision    : 1.0 - initial release
// ============================================================================
module mat_result_fifo
    import mat_mul_pkg::*;
#(
    parameter int DATA_W = RES_W,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [MAT_WORDS*DATA_W-1:0] wdata,
    output logic [MAT_WORDS*DATA_W-1:0] rdata,
    output logic                        full,
    output logic                        empty,
    output logic [CNT_W-1:0]            count
);

    logic [MAT_WORDS*DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [CNT_W-1:0]            r_count;

    // Matrix storage; contents are only meaningful below the occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (pop && !push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule : mat_result_fifo
`default_nettype wire

// File: rtl/mat_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : mat_result_serializer
// Description : Captures finished 2x2 result matrices into a small queue and
//               streams them one word per beat (w,x,y,z) over valid/ready,
//               flagging the last word and counting matrices dropped while
//               the queue is full.
// Revision    : 1.0 - initial release
// ============================================================================
module mat_result_serializer
    import mat_mul_pkg::*;
#(
    parameter int DATA_W = RES_W,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     w,
    input  logic [DATA_W-1:0]     x,
    input  logic [DATA_W-1:0]     y,
    input  logic [DATA_W-1:0]     z,
    output logic                  can_accept,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [WORD_IDX_W-1:0] out_idx,
    output logic                  out_last,
    output logic [DROP_W-1:0]     drop_cnt,
    input  logic                  drop_clr
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [0:0]                  r_state;
    logic [WORD_IDX_W-1:0]       r_out_idx;
    logic                        r_out_last;
    logic [DROP_W-1:0]           r_drop_cnt;

    logic [MAT_WORDS*DATA_W-1:0] w_rdata;
    logic                        w_full;
    logic                        w_empty;
    logic [CNT_W-1:0]            w_count;
    logic                        w_handshake;
    logic                        w_pop;
    logic                        w_push;
    logic                        w_drop;
    logic                        w_last_empties;
    logic [DATA_W-1:0]           w_words [MAT_WORDS];

    // A slot freed by the final-word pop this cycle can take the new matrix
    assign w_handshake    = (r_state == RS_SEND) && out_ready;
    assign w_pop          = w_handshake && (r_out_idx == WORD_IDX_W'(IDX_Z));
    assign w_push         = in_valid && (!w_full || w_pop);
    assign w_drop         = in_valid && w_full && !w_pop;
    assign w_last_empties = w_pop && !w_push && (w_count == CNT_W'(1));

    mat_result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (w_push),
        .pop    (w_pop),
        .wdata  ({w, x, y, z}),
        .rdata  (w_rdata),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count)
    );

    // Split the stored matrix back into words; w sits in the top slice
    for (genvar gi = 0; gi < MAT_WORDS; gi++) begin : g_word
        assign w_words[gi] = w_rdata[(MAT_WORDS-1-gi)*DATA_W +: DATA_W];
    end

    // Read FSM: presents the head matrix word by word, outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RS_EMPTY;
            r_out_idx  <= '0;
            r_out_last <= 1'b0;
        end else begin
            case (r_state)
                RS_EMPTY: begin
                    if (w_push || !w_empty) begin
                        r_state <= RS_SEND;
                    end
                end
                RS_SEND: begin
                    if (w_handshake) begin
                        r_out_idx  <= r_out_idx + WORD_IDX_W'(1);
                        r_out_last <= (r_out_idx == WORD_IDX_W'(IDX_Y));
                        if (w_last_empties) begin
                            r_state <= RS_EMPTY;
                        end
                    end
                end
                default: begin
                    r_state <= RS_EMPTY;
                end
            endcase
        end
    end

    // Saturating count of discarded matrices; clear wins over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (drop_clr) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {DROP_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
    end

    assign can_accept = !w_full;
    assign out_valid  = (r_state == RS_SEND);
    assign out_data   = w_words[r_out_idx];
    assign out_idx    = r_out_idx;
    assign out_last   = r_out_last;
    assign drop_cnt   = r_drop_cnt;

endmodule : mat_result_serializer
`default_nettype wire

// File: tb/tb_mat_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mat_result_serializer
// Description : Self-checking bench for mat_result_serializer. A queue of
//               whole matrices plus a word index and drop count predicts
//               every output after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_result_serializer;

    localparam int C_DEPTH  = 4;
    localparam int C_DROP_W = 2;
    localparam int C_DROP_MAX = (1 << C_DROP_W) - 1;

    typedef logic [3:0][31:0] mat_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic [31:0]         w = '0;
    logic [31:0]         x = '0;
    logic [31:0]         y = '0;
    logic [31:0]         z = '0;
    logic                can_accept;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [31:0]         out_data;
    logic [1:0]          out_idx;
    logic                out_last;
    logic [C_DROP_W-1:0] drop_cnt;
    logic                drop_clr = 1'b0;

    int tests_run = 0;
    int fails = 0;

    // Reference state: queued matrices, word position in the head, drops
    mat_t mq[$];
    int   m_idx = 0;
    int   m_drop = 0;

    mat_result_serializer #(
        .DATA_W (32),
        .DEPTH  (C_DEPTH),
        .DROP_W (C_DROP_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .w          (w),
        .x          (x),
        .y          (y),
        .z          (z),
        .can_accept (can_accept),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .drop_cnt   (drop_cnt),
        .drop_clr   (drop_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        check("can_accept", 32'(can_accept), 32'(mq.size() < C_DEPTH));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        check("out_idx", 32'(out_idx), 32'(m_idx));
        check("out_last", 32'(out_last), 32'(m_idx == 3));
        if (mq.size() > 0) begin
            check("out_data", out_data, mq[0][m_idx]);
        end
    endtask

    // Advance the reference across one clock edge given the pre-edge inputs
    task automatic model_edge(input bit iv, input mat_t m, input bit rdy, input bit clr);
        bit hs;
        bit dropped;
        hs = (mq.size() > 0) && rdy;
        dropped = 1'b0;
        if (hs) begin
            if (m_idx == 3) begin
                void'(mq.pop_front());
                m_idx = 0;
            end else begin
                m_idx = m_idx + 1;
            end
        end
        if (iv) begin
            if (mq.size() < C_DEPTH) mq.push_back(m);
            else dropped = 1'b1;
        end
        if (clr) m_drop = 0;
        else if (dropped && m_drop < C_DROP_MAX) m_drop = m_drop + 1;
    endtask

    task automatic step(input bit iv, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d,
                        input bit rdy, input bit clr);
        mat_t m;
        m[0] = a; m[1] = b; m[2] = c; m[3] = d;
        in_valid  = iv;
        w = a; x = b; y = c; z = d;
        out_ready = rdy;
        drop_clr  = clr;
        @(posedge clk);
        model_edge(iv, m, rdy, clr);
        #1;
        in_valid = 1'b0;
        drop_clr = 1'b0;
        compare_all();
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, rdy, 1'b0);
    endtask

    initial begin
        bit [6:0] toggles;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;

        // 1: single matrix, consumer always ready
        step(1'b1, 32'd5, 32'hFFFF_FFF6, 32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0);
        idle(1'b1, 4);
        check("t1_drained", 32'(out_valid), 32'd0);

        // 2: backpressure pattern 1,0,0,1,1,0,1 (one word per high beat)
        step(1'b1, 32'd5, 32'hFFFF_FFF6, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b0);
        toggles = 7'b1011001;
        for (int i = 0; i < 7; i++) step(1'b0, '0, '0, '0, '0, toggles[i], 1'b0);
        check("t2_drained", 32'(out_valid), 32'd0);

        // 3: fill with tags 1..5 while stalled; fifth is dropped
        for (int i = 1; i <= 5; i++)
            step(1'b1, 32'(i), 32'(i + 100), 32'(i + 200), 32'(i + 300), 1'b0, 1'b0);
        check("t3_drop_one", 32'(drop_cnt), 32'd1);
        idle(1'b1, 17);
        step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        check("t3_drop_clr", 32'(drop_cnt), 32'd0);

        // 4: full queue, new matrix arrives alongside the final-word pop
        for (int i = 11; i <= 14; i++)
            step(1'b1, 32'(i), 32'(i + 1000), 32'(i + 2000), 32'(i + 3000), 1'b0, 1'b0);
        idle(1'b1, 3);
        step(1'b1, 32'd9, 32'd19, 32'd29, 32'd39, 1'b1, 1'b0);
        check("t4_no_drop", 32'(drop_cnt), 32'd0);
        check("t4_still_full", 32'(can_accept), 32'd0);
        idle(1'b1, 12);
        check("t4_last_is_9", out_data, 32'd9);
        idle(1'b1, 5);

        // 6: drop counter saturation with six extra pulses
        for (int i = 0; i < 10; i++)
            step(1'b1, 32'(40 + i), 32'(50 + i), 32'(60 + i), 32'(70 + i), 1'b0, 1'b0);
        check("t6_saturated", 32'(drop_cnt), 32'(C_DROP_MAX));

        // 5: reset asserted asynchronously after two beats of the head
        idle(1'b1, 2);
        #1 reset = 1'b1;
        #1;
        mq.delete();
        m_idx = 0;
        m_drop = 0;
        compare_all();
        #3 reset = 1'b0;
        step(1'b1, 32'hDEAD_BEEF, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("t5_restart_idx", 32'(out_idx), 32'd0);
        idle(1'b1, 5);

        // Randomized traffic against the reference queue
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 40, $urandom, $urandom, $urandom, $urandom,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 5);
        idle(1'b1, 20);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule : tb_mat_result_serializer
`default_nettype wire
